// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode selectors and the pointer-width helper
// used by both the single-clock and the dual-clock FIFOs.
package fifo_pkg;

  // Read-side presentation modes
  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

  // Pointer width: one extra bit over the RAM index so full and empty are distinguishable
  function automatic int unsigned ptr_width(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

endpackage : fifo_pkg

// File: rtl/fifo_ram.sv
// Simple dual-port storage for the FIFOs: synchronous write, asynchronous read,
// no reset (contents are meaningless until written).
module fifo_ram #(
  parameter int unsigned data_width = 32,
  parameter int unsigned fifo_depth = 8,
  parameter int unsigned addr_width = $clog2(fifo_depth)
) (
  input  logic                  clk,
  input  logic                  w_en,
  input  logic [addr_width-1:0] w_addr,
  input  logic [data_width-1:0] w_data,
  input  logic [addr_width-1:0] r_addr,
  output logic [data_width-1:0] r_data_c
);

  logic [data_width-1:0] mem [fifo_depth];

  // Write port
  always_ff @(posedge clk) begin
    if (w_en) begin
      mem[w_addr] <= w_data;
    end
  end

  // Read port is a plain mux; the top registers the result
  assign r_data_c = mem[r_addr];

endmodule : fifo_ram

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count, almost-full/almost-empty thresholds
// and either a registered read or first-word-fall-through presentation.
// Optional sticky overflow/underflow flags are built when SYNC_FIFO_ERR_EN is
// defined; otherwise both ports are tied low.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned data_width          = 32,
  parameter int unsigned fifo_depth          = 8,
  parameter int unsigned almost_full_thresh  = fifo_depth - 1,
  parameter int unsigned almost_empty_thresh = 1,
  parameter int unsigned fwft                = FIFO_MODE_STD,
  localparam int unsigned addr_width         = $clog2(fifo_depth)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [data_width-1:0] w_data,
  output logic                  full,
  output logic                  almost_full,
  input  logic                  r_en,
  output logic [data_width-1:0] r_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [addr_width:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned ptr_w   = ptr_width(fifo_depth);
  localparam bit          is_fwft = (fwft == FIFO_MODE_FWFT);

  // Registered state
  logic [ptr_w-1:0]      w_ptr_q;
  logic [ptr_w-1:0]      r_ptr_q;
  logic [ptr_w-1:0]      vis_ptr_q;
  logic                  valid_q;
  logic [data_width-1:0] r_data_q;
  logic [ptr_w-1:0]      count_q;
  logic                  full_q;
  logic                  empty_q;
  logic                  af_q;
  logic                  ae_q;

  // Next-state values
  logic [ptr_w-1:0]      w_ptr_d;
  logic [ptr_w-1:0]      r_ptr_d;
  logic                  valid_d;
  logic [data_width-1:0] r_data_d;
  logic [ptr_w-1:0]      count_d;
  logic                  full_d;
  logic                  empty_d;
  logic                  af_d;
  logic                  ae_d;

  logic                  wr_acc;
  logic                  rd_acc;
  logic                  load;
  logic [ptr_w-1:0]      vis_cnt;
  logic                  ram_we;
  logic [data_width-1:0] ram_rd;

  // RAM writes are suppressed during reset so the reset cycle has no side effects
  assign ram_we = wr_acc & ~rst;

  fifo_ram #(
    .data_width (data_width),
    .fifo_depth (fifo_depth),
    .addr_width (addr_width)
  ) u_ram (
    .clk      (clk),
    .w_en     (ram_we),
    .w_addr   (w_ptr_q[addr_width-1:0]),
    .w_data   (w_data),
    .r_addr   (r_ptr_q[addr_width-1:0]),
    .r_data_c (ram_rd)
  );

  // Next pointers, read data and flags, all derived from cycle-start state
  always_comb begin
    wr_acc   = w_en & ~full_q;
    rd_acc   = r_en & ~empty_q;
    vis_cnt  = vis_ptr_q - r_ptr_q;
    load     = 1'b0;
    w_ptr_d  = w_ptr_q + ptr_w'(wr_acc);
    r_ptr_d  = r_ptr_q;
    valid_d  = valid_q;
    r_data_d = r_data_q;
    count_d  = count_q;
    empty_d  = empty_q;

    if (is_fwft) begin
      // Refill the output register when it is free or being popped; the RAM
      // side only sees words written at least one cycle ago (vis_ptr_q)
      load     = (vis_cnt != '0) & (~valid_q | rd_acc);
      r_ptr_d  = r_ptr_q + ptr_w'(load);
      valid_d  = load | (valid_q & ~rd_acc);
      if (load) begin
        r_data_d = ram_rd;
      end
      count_d  = w_ptr_d - r_ptr_d + ptr_w'(valid_d);
      empty_d  = ~valid_d;
    end else begin
      r_ptr_d  = r_ptr_q + ptr_w'(rd_acc);
      if (rd_acc) begin
        r_data_d = ram_rd;
      end
      count_d  = w_ptr_d - r_ptr_d;
      empty_d  = (count_d == '0);
    end

    full_d = (count_d == ptr_w'(fifo_depth));
    af_d   = (count_d >= ptr_w'(almost_full_thresh));
    ae_d   = (count_d <= ptr_w'(almost_empty_thresh));
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      w_ptr_q   <= '0;
      r_ptr_q   <= '0;
      vis_ptr_q <= '0;
      valid_q   <= 1'b0;
      r_data_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
    end else begin
      w_ptr_q   <= w_ptr_d;
      r_ptr_q   <= r_ptr_d;
      vis_ptr_q <= w_ptr_q;
      valid_q   <= valid_d;
      r_data_q  <= r_data_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      af_q      <= af_d;
      ae_q      <= ae_d;
    end
  end

  assign full         = full_q;
  assign almost_full  = af_q;
  assign empty        = empty_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign r_data       = r_data_q;

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Sticky error flags: only reset clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_q  | (w_en & full_q);
      underflow_q <= underflow_q | (r_en & empty_q);
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a standard-read instance driven from a vector
// table plus hand sequences, and an FWFT instance driven by hand sequences.
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_EN
  localparam bit err_en = 1'b1;
`else
  localparam bit err_en = 1'b0;
`endif

  logic clk;

  // Standard-read instance
  logic       s_rst, s_w_en, s_r_en;
  logic [7:0] s_w_data, s_r_data;
  logic       s_full, s_af, s_empty, s_ae, s_ov, s_un;
  logic [3:0] s_count;

  // FWFT instance
  logic       f_rst, f_w_en, f_r_en;
  logic [7:0] f_w_data, f_r_data;
  logic       f_full, f_af, f_empty, f_ae, f_ov, f_un;
  logic [3:0] f_count;

  int n_checks = 0;
  int n_fails  = 0;

  sync_fifo #(.data_width(8), .fifo_depth(8), .fwft(0)) u_std (
    .clk(clk), .rst(s_rst), .w_en(s_w_en), .w_data(s_w_data),
    .full(s_full), .almost_full(s_af), .r_en(s_r_en), .r_data(s_r_data),
    .empty(s_empty), .almost_empty(s_ae), .count(s_count),
    .overflow(s_ov), .underflow(s_un)
  );

  sync_fifo #(.data_width(8), .fifo_depth(8), .fwft(1)) u_fw (
    .clk(clk), .rst(f_rst), .w_en(f_w_en), .w_data(f_w_data),
    .full(f_full), .almost_full(f_af), .r_en(f_r_en), .r_data(f_r_data),
    .empty(f_empty), .almost_empty(f_ae), .count(f_count),
    .overflow(f_ov), .underflow(f_un)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       w_en;
    logic [7:0] w_data;
    logic       r_en;
    int         exp_count;
    logic [7:0] exp_r_data;
    logic       exp_ov;
    logic       exp_un;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic we, input logic [7:0] wd,
                              input logic re, input int cnt, input logic [7:0] rd,
                              input logic ov, input logic un);
    vec_t v;
    v.rst = rst; v.w_en = we; v.w_data = wd; v.r_en = re;
    v.exp_count = cnt; v.exp_r_data = rd; v.exp_ov = ov; v.exp_un = un;
    vecs.push_back(v);
  endfunction

  task automatic cmp(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Standard instance: flags follow the count with default thresholds 7 and 1
  task automatic check_s(input string tag, input int cnt, input logic [7:0] rd,
                         input logic ov, input logic un);
    cmp({tag, ".count"},  int'(s_count), cnt);
    cmp({tag, ".empty"},  int'(s_empty), int'(cnt == 0));
    cmp({tag, ".full"},   int'(s_full),  int'(cnt == 8));
    cmp({tag, ".afull"},  int'(s_af),    int'(cnt >= 7));
    cmp({tag, ".aempty"}, int'(s_ae),    int'(cnt <= 1));
    cmp({tag, ".r_data"}, int'(s_r_data), int'(rd));
    cmp({tag, ".ovf"},    int'(s_ov),    int'(ov));
    cmp({tag, ".unf"},    int'(s_un),    int'(un));
  endtask

  // FWFT instance: empty tracks the output register, so it is given explicitly
  task automatic check_f(input string tag, input int cnt, input logic emp,
                         input logic [7:0] rd, input bit chk_rd,
                         input logic ov, input logic un);
    cmp({tag, ".count"},  int'(f_count), cnt);
    cmp({tag, ".empty"},  int'(f_empty), int'(emp));
    cmp({tag, ".full"},   int'(f_full),  int'(cnt == 8));
    cmp({tag, ".afull"},  int'(f_af),    int'(cnt >= 7));
    cmp({tag, ".aempty"}, int'(f_ae),    int'(cnt <= 1));
    if (chk_rd) cmp({tag, ".r_data"}, int'(f_r_data), int'(rd));
    cmp({tag, ".ovf"},    int'(f_ov),    int'(ov));
    cmp({tag, ".unf"},    int'(f_un),    int'(un));
  endtask

  task automatic stp_s(input logic rst, input logic we, input logic [7:0] wd, input logic re);
    s_rst = rst; s_w_en = we; s_w_data = wd; s_r_en = re;
    @(posedge clk); #1;
  endtask

  task automatic stp_f(input logic rst, input logic we, input logic [7:0] wd, input logic re);
    f_rst = rst; f_w_en = we; f_w_data = wd; f_r_en = re;
    @(posedge clk); #1;
  endtask

  initial begin
    s_rst = 1'b1; s_w_en = 1'b0; s_w_data = '0; s_r_en = 1'b0;
    f_rst = 1'b1; f_w_en = 1'b0; f_w_data = '0; f_r_en = 1'b0;

    // Fill / overflow / drain / underflow / full+both / empty+both
    add(1, 0, 8'h00, 0, 0, 8'h00, 0, 0);
    for (int k = 1; k <= 8; k++) add(0, 1, 8'(k), 0, k, 8'h00, 0, 0);
    add(0, 1, 8'hFF, 0, 8, 8'h00, err_en, 0);
    for (int k = 1; k <= 8; k++) add(0, 0, 8'h00, 1, 8 - k, 8'(k), err_en, 0);
    add(0, 0, 8'h00, 1, 0, 8'h08, err_en, err_en);
    for (int k = 1; k <= 8; k++) add(0, 1, 8'(8'h10 + k), 0, k, 8'h08, err_en, err_en);
    add(0, 1, 8'hEE, 1, 7, 8'h11, err_en, err_en);
    for (int k = 2; k <= 8; k++) add(0, 0, 8'h00, 1, 8 - k, 8'(8'h10 + k), err_en, err_en);
    add(0, 1, 8'h33, 1, 1, 8'h18, err_en, err_en);
    add(0, 0, 8'h00, 1, 0, 8'h33, err_en, err_en);

    foreach (vecs[i]) begin
      stp_s(vecs[i].rst, vecs[i].w_en, vecs[i].w_data, vecs[i].r_en);
      check_s($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_r_data,
              vecs[i].exp_ov, vecs[i].exp_un);
    end

    // Wrap: steady count of 3 with simultaneous write+read across pointer wrap
    stp_s(1, 0, 8'h00, 0);
    check_s("wrap.rst", 0, 8'h00, 0, 0);
    for (int k = 0; k < 3; k++) stp_s(0, 1, 8'(8'h40 + k), 0);
    check_s("wrap.prefill", 3, 8'h00, 0, 0);
    for (int i = 0; i < 20; i++) begin
      stp_s(0, 1, 8'(8'h43 + i), 1);
      check_s($sformatf("wrap%0d", i), 3, 8'(8'h40 + i), 0, 0);
    end
    for (int k = 0; k < 3; k++) begin
      stp_s(0, 0, 8'h00, 1);
      check_s($sformatf("wrap.drain%0d", k), 2 - k, 8'(8'h54 + k), 0, 0);
    end

    // Reset mid-stream at count 5 with a sticky flag set beforehand
    stp_s(1, 0, 8'h00, 0);
    stp_s(0, 0, 8'h00, 1);
    check_s("mid.unf", 0, 8'h00, 0, err_en);
    for (int k = 1; k <= 6; k++) stp_s(0, 1, 8'(8'h50 + k), 0);
    stp_s(0, 0, 8'h00, 1);
    check_s("mid.pre", 5, 8'h51, 0, err_en);
    stp_s(1, 0, 8'h00, 0);
    check_s("mid.rst", 0, 8'h00, 0, 0);
    stp_s(0, 1, 8'h99, 0);
    check_s("mid.wr", 1, 8'h00, 0, 0);
    stp_s(0, 0, 8'h00, 1);
    check_s("mid.rd", 0, 8'h99, 0, 0);

    // FWFT: two-cycle fall-through latency on a single word
    stp_f(1, 0, 8'h00, 0);
    check_f("fw.rst", 0, 1, 8'h00, 1, 0, 0);
    stp_f(0, 1, 8'hA5, 0);
    check_f("fw.wr", 1, 1, 8'h00, 1, 0, 0);
    stp_f(0, 0, 8'h00, 0);
    check_f("fw.lat1", 1, 1, 8'h00, 1, 0, 0);
    stp_f(0, 0, 8'h00, 0);
    check_f("fw.lat2", 1, 0, 8'hA5, 1, 0, 0);
    stp_f(0, 1, 8'hB6, 0);
    check_f("fw.wrB6", 2, 0, 8'hA5, 1, 0, 0);
    stp_f(0, 1, 8'hC7, 0);
    check_f("fw.wrC7", 3, 0, 8'hA5, 1, 0, 0);
    stp_f(0, 0, 8'h00, 0);
    stp_f(0, 0, 8'h00, 1);
    check_f("fw.pop1", 2, 0, 8'hB6, 1, 0, 0);
    stp_f(0, 0, 8'h00, 1);
    check_f("fw.pop2", 1, 0, 8'hC7, 1, 0, 0);
    stp_f(0, 0, 8'h00, 1);
    check_f("fw.pop3", 0, 1, 8'h00, 0, 0, 0);

    // FWFT: fill to capacity, overflow, then bubble-free drain
    for (int k = 1; k <= 8; k++) begin
      stp_f(0, 1, 8'(k), 0);
      check_f($sformatf("fw.fill%0d", k), k, logic'(k < 3), 8'h01, bit'(k >= 3), 0, 0);
    end
    stp_f(0, 1, 8'hFF, 0);
    check_f("fw.ovf", 8, 0, 8'h01, 1, err_en, 0);
    for (int k = 1; k <= 8; k++) begin
      stp_f(0, 0, 8'h00, 1);
      check_f($sformatf("fw.drain%0d", k), 8 - k, logic'(k == 8), 8'(k + 1), bit'(k < 8), err_en, 0);
    end
    stp_f(0, 0, 8'h00, 1);
    check_f("fw.unf", 0, 1, 8'h00, 0, err_en, err_en);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_sync_fifo
